// File: rtl/synth_pkg.sv
// Shared types and sizing for the tone synthesis voice path.
package synth_pkg;

    localparam int unsigned MIN_DIV_DEFAULT = 256;
    localparam int unsigned DIV_W           = 16;
    localparam int unsigned SAMPLE_W        = 8;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'b00,
        WAVE_SAW    = 2'b01,
        WAVE_TRI    = 2'b10,
        WAVE_MUTE   = 2'b11
    } wave_t;

    typedef enum logic {
        OSC_IDLE,
        OSC_RUN
    } osc_state_t;

endpackage

// File: rtl/tone_oscillator_if.sv
// Voice control in, audio sample and period status out.
interface tone_oscillator_if;
    import synth_pkg::*;

    logic                en;
    logic [DIV_W-1:0]    divider;
    logic [1:0]          wave_sel;
    logic [SAMPLE_W-1:0] sample;
    logic                period_start;
    logic                active;

    modport master (
        output en, divider, wave_sel,
        input  sample, period_start, active
    );

    modport slave (
        input  en, divider, wave_sel,
        output sample, period_start, active
    );

endinterface

// File: rtl/phase_ramp.sv
// Period counter with a fractional accumulator producing ramp = floor(256*cnt/act_div).
module phase_ramp
    import synth_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                step,
    input  logic [DIV_W-1:0]    act_div,
    output logic [SAMPLE_W-1:0] ramp,
    output logic                first,
    output logic                last
);

    logic [DIV_W-1:0]    cnt;
    logic [DIV_W-1:0]    acc;
    logic [SAMPLE_W-1:0] ramp_q;
    logic [DIV_W:0]      acc_sum;
    logic                wrap;

    // acc holds 256*cnt mod act_div; act_div >= 256 bounds each ramp step to 1
    assign acc_sum = {1'b0, acc} + (DIV_W+1)'(256);
    assign wrap    = acc_sum >= {1'b0, act_div};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            ramp_q <= '0;
        end else if (clear) begin
            cnt    <= '0;
            acc    <= '0;
            ramp_q <= '0;
        end else if (step) begin
            cnt <= cnt + DIV_W'(1);
            if (wrap) begin
                acc    <= DIV_W'(acc_sum - {1'b0, act_div});
                ramp_q <= ramp_q + SAMPLE_W'(1);
            end else begin
                acc    <= DIV_W'(acc_sum);
            end
        end
    end

    assign ramp  = ramp_q;
    assign first = (cnt == '0);
    assign last  = (cnt == act_div - DIV_W'(1));

endmodule

// File: rtl/tone_oscillator.sv
// Single-voice oscillator: divider-driven period, square/saw/triangle decode.
module tone_oscillator
    import synth_pkg::*;
#(
    parameter int unsigned         MIN_DIV     = MIN_DIV_DEFAULT,
    parameter logic [SAMPLE_W-1:0] SILENCE_LVL = 8'd0
) (
    input  logic             clk,
    input  logic             rst,
    tone_oscillator_if.slave bus
);

    osc_state_t          state;
    osc_state_t          state_nxt;
    logic [DIV_W-1:0]    act_div;
    logic [DIV_W-1:0]    act_div_nxt;
    logic                clear;
    logic                step;
    logic                div_ok;
    logic [SAMPLE_W-1:0] ramp;
    logic                first;
    logic                last;
    logic [SAMPLE_W-1:0] tri_c;
    logic [SAMPLE_W-1:0] sample_c;

    assign div_ok = bus.divider >= DIV_W'(MIN_DIV);

    phase_ramp u_phase_ramp (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .step    (step),
        .act_div (act_div),
        .ramp    (ramp),
        .first   (first),
        .last    (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= OSC_IDLE;
            act_div <= '0;
        end else begin
            state   <= state_nxt;
            act_div <= act_div_nxt;
        end
    end

    // New dividers are only latched at a period boundary so note changes never glitch
    always_comb begin
        state_nxt   = state;
        act_div_nxt = act_div;
        clear       = 1'b1;
        step        = 1'b0;
        case (state)
            OSC_IDLE: begin
                if (bus.en && div_ok) begin
                    state_nxt   = OSC_RUN;
                    act_div_nxt = bus.divider;
                end
            end
            OSC_RUN: begin
                if (!bus.en) begin
                    state_nxt = OSC_IDLE;
                end else if (last) begin
                    if (div_ok) begin
                        act_div_nxt = bus.divider;
                    end else begin
                        state_nxt = OSC_IDLE;
                    end
                end else begin
                    clear = 1'b0;
                    step  = 1'b1;
                end
            end
            default: state_nxt = OSC_IDLE;
        endcase
    end

    assign tri_c = {ramp[SAMPLE_W-2:0], 1'b0};

    always_comb begin
        sample_c = SILENCE_LVL;
        if (state == OSC_RUN) begin
            case (wave_t'(bus.wave_sel))
                WAVE_SQUARE: sample_c = ramp[SAMPLE_W-1] ? 8'h00 : 8'hFF;
                WAVE_SAW:    sample_c = ramp;
                WAVE_TRI:    sample_c = ramp[SAMPLE_W-1] ? ~tri_c : tri_c;
                WAVE_MUTE:   sample_c = SILENCE_LVL;
                default:     sample_c = SILENCE_LVL;
            endcase
        end
    end

    assign bus.sample       = sample_c;
    assign bus.period_start = (state == OSC_RUN) && first;
    assign bus.active       = (state == OSC_RUN);

endmodule

// File: tb/tb_tone_oscillator.sv
// Scoreboard bench for tone_oscillator against an arithmetic per-period reference model.
module tb_tone_oscillator;
    import synth_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tone_oscillator_if bus();

    tone_oscillator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] sample;
        logic       ps;
        logic       act;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference: running flag, position k within the period, period length d
    bit          m_run;
    int unsigned m_k;
    int unsigned m_d;

    task automatic model_reset();
        m_run = 1'b0;
        m_k   = 0;
        m_d   = 0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (!m_run) begin
            if (bus.en && bus.divider >= 16'd256) begin
                m_run = 1'b1;
                m_k   = 0;
                m_d   = bus.divider;
            end
        end else if (!bus.en) begin
            m_run = 1'b0;
        end else if (m_k == m_d - 1) begin
            if (bus.divider < 16'd256) begin
                m_run = 1'b0;
            end else begin
                m_k = 0;
                m_d = bus.divider;
            end
        end else begin
            m_k = m_k + 1;
        end
    endtask

    function automatic exp_t expect_now();
        exp_t        e;
        int unsigned r;
        e.sample = 8'h00;
        e.ps     = 1'b0;
        e.act    = m_run;
        if (m_run) begin
            r    = (256 * m_k) / m_d;
            e.ps = (m_k == 0);
            case (bus.wave_sel)
                2'b00:   e.sample = (r < 128) ? 8'hFF : 8'h00;
                2'b01:   e.sample = 8'(r);
                2'b10:   e.sample = (r < 128) ? 8'(2 * r) : 8'(255 - 2 * (r - 128));
                default: e.sample = 8'h00;
            endcase
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, want);
        end
    endtask

    task automatic step(input logic rst_i, input logic en_i, input logic [15:0] div_i,
                        input logic [1:0] ws_i);
        @(posedge clk);
        model_edge();
        #1;
        rst          = rst_i;
        bus.en       = en_i;
        bus.divider  = div_i;
        bus.wave_sel = ws_i;
        if (rst) model_reset();
        exp_q.push_back(expect_now());
    endtask

    task automatic run(input int n, input logic en_i, input logic [15:0] div_i,
                       input logic [1:0] ws_i);
        for (int i = 0; i < n; i++) step(1'b0, en_i, div_i, ws_i);
    endtask

    // Reset lands between edges; outputs must clear without waiting for a clock
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_sample", 32'(bus.sample), 32'h0);
        check("async_rst_active", 32'(bus.active), 32'h0);
        check("async_rst_period_start", 32'(bus.period_start), 32'h0);
        model_reset();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (bus.sample !== e.sample || bus.period_start !== e.ps || bus.active !== e.act) begin
                miscompares++;
                $display("FAIL out_check t=%0t got sample=%h ps=%b act=%b expected sample=%h ps=%b act=%b",
                         $time, bus.sample, bus.period_start, bus.active, e.sample, e.ps, e.act);
            end
        end
    end

    initial begin
        int          len;
        int          pick;
        logic        e_r;
        logic [15:0] d_r;
        logic [1:0]  w_r;

        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.divider  = '0;
        bus.wave_sel = '0;
        model_reset();

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'd0, WAVE_SAW);

        // Shortest divider, sawtooth tracks cnt directly
        run(600, 1'b1, 16'd256, WAVE_SAW);
        run(3, 1'b0, 16'd0, WAVE_SAW);

        // Low C square: one full long period plus the next boundary
        run(38223 + 300, 1'b1, 16'd38223, WAVE_SQUARE);
        run(3, 1'b0, 16'd0, WAVE_SQUARE);

        run(1100, 1'b1, 16'd512, WAVE_TRI);
        run(3, 1'b0, 16'd0, WAVE_TRI);

        // Divider change mid-period waits for the boundary
        run(101, 1'b1, 16'd256, WAVE_SAW);
        run(1200, 1'b1, 16'd512, WAVE_SAW);
        run(3, 1'b0, 16'd0, WAVE_SAW);

        run(50, 1'b1, 16'd100, WAVE_SAW);
        run(50, 1'b1, 16'd0, WAVE_SQUARE);
        run(50, 1'b1, 16'd255, WAVE_SQUARE);

        run(100, 1'b1, 16'd256, WAVE_SAW);
        run(300, 1'b1, 16'd0, WAVE_SAW);

        run(100, 1'b1, 16'd300, WAVE_SQUARE);
        run(20, 1'b0, 16'd300, WAVE_SQUARE);

        run(130, 1'b1, 16'd256, WAVE_SAW);
        async_reset();
        step(1'b0, 1'b1, 16'd256, WAVE_SAW);
        run(300, 1'b1, 16'd256, WAVE_SAW);

        for (int s = 0; s < 40; s++) begin
            len  = $urandom_range(50, 600);
            e_r  = ($urandom_range(0, 7) != 0);
            pick = $urandom_range(0, 9);
            case (pick)
                0:       d_r = 16'd0;
                1:       d_r = 16'd100;
                2:       d_r = 16'd255;
                3:       d_r = 16'd256;
                default: d_r = 16'($urandom_range(256, 1500));
            endcase
            w_r = 2'($urandom_range(0, 3));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 15) == 0) w_r = 2'($urandom_range(0, 3));
                step(1'b0, e_r, d_r, w_r);
            end
            if ($urandom_range(0, 9) == 0) begin
                async_reset();
                step(1'b0, e_r, d_r, w_r);
            end
        end

        run(2, 1'b0, 16'd0, WAVE_SAW);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tone_oscillator.md
Name: tone_oscillator

Overview:
- Downstream consumer of the keycode/sound-series divider LUT. Takes the 16-bit clocks-per-period divider and produces an 8-bit unsigned audio sample (square, sawtooth or triangle) at the note frequency.
- A divider of 0 means silence.
- Divider changes are applied only at period boundaries, so note changes are glitch-free.
- Output feeds the PWM/DAC output stage.

Parameters:
- MIN_DIV, 256, smallest divider that produces sound. Values 1..MIN_DIV-1 are treated as silence. Must be at least 256 so the ramp steps by at most 1 per clock.
- SILENCE_LVL, 8'd0, sample value driven while idle or silent.

Ports:
- clk  in  1  system clock (10 MHz ASIC / 12 MHz FPGA)
- rst  in  1  reset, asynchronous, active-high
- en  in  1  voice enable, synchronous
- divider  in  16  clocks per waveform period, from the LUT stage; 0 = silence
- wave_sel  in  2  waveform select: 00 square, 01 sawtooth, 10 triangle, 11 mute
- sample  out  8  unsigned audio sample
- period_start  out  1  one-cycle pulse on the first clock of each period
- active  out  1  high while in RUN

Behaviour:
- Registered state: fsm {IDLE, RUN}, cnt[15:0], acc[15:0], ramp[7:0], act_div[15:0].
- Reset (async, rst=1): fsm=IDLE; all registers 0. Outputs: sample=SILENCE_LVL, period_start=0, active=0.
- IDLE:
  - cnt=acc=ramp=0.
  - If en=1 and divider>=MIN_DIV: act_div<=divider and fsm<=RUN on the next edge.
  - The first RUN cycle has cnt=0 and period_start=1.
- RUN, every clock:
  - If cnt==act_div-1, this is the last cycle of the period. Next cycle: cnt=0, acc=0, ramp=0, period_start=1, act_div<=divider (sampled on that edge).
  - If the sampled divider<MIN_DIV, go to IDLE instead.
  - Otherwise cnt<=cnt+1 and t=acc+256 (17-bit compare):
    - if t>=act_div: acc<=t-act_div, ramp<=ramp+1;
    - else acc<=t.
  - Result: ramp = floor(256*cnt/act_div), reaching 255 on the last cycle.
- en=0 while in RUN: fsm<=IDLE on that edge, abandoning the period immediately. Sample reads SILENCE_LVL from the next cycle.
- Divider changes mid-period are ignored until the boundary. The LUT output is treated as quasi-static; no synchronizer is needed.
- Sample decode is combinational from registered state and wave_sel. wave_sel may change at any time and takes effect immediately.
  - Square: ramp[7]=0 gives 8'hFF, else 8'h00.
  - Saw: ramp.
  - Triangle: ramp[7]=0 gives {ramp[6:0],1'b0}; else gives ~{ramp[6:0],1'b0}.
  - Mute: SILENCE_LVL.
  - In IDLE, sample=SILENCE_LVL regardless of wave_sel.
- period_start = (fsm==RUN && cnt==0). It also pulses on the first RUN cycle.
- active = (fsm==RUN).
- Reset mid-period: immediate return to the reset values above. No pending divider is retained.

Decomposition:
- synth_pkg holds:
  - wave_t enum {WAVE_SQUARE=2'b00, WAVE_SAW=2'b01, WAVE_TRI=2'b10, WAVE_MUTE=2'b11}
  - osc_state_t enum {OSC_IDLE, OSC_RUN}
  - localparams MIN_DIV_DEFAULT=256, DIV_W=16, SAMPLE_W=8
- One sub-module, phase_ramp: holds the cnt/acc/ramp counters. Inputs: clear, step, act_div. Outputs: ramp, last.
- The FSM, act_div register and waveform decode stay in tone_oscillator.

Test Plan:
- Divider=256, en=1, saw: ramp equals cnt; sample steps 0,1,...,255 then returns to 0. period_start repeats exactly every 256 clocks. active=1 from the 2nd clock after en.
- Divider=38223 (C low), square: sample=8'hFF for 19112 clocks, then 8'h00 for 19111 clocks. period_start spacing is 38223.
- Divider=512, triangle: sample 0,0,2,2,...,254,254 then 255,255,253,...,1,1. Over one period the peak is 255 at cnt=256 and the minimum is 0.
- Divider changes 256→512 at cnt=100: current period still ends at 256 clocks; the next period is 512 clocks, with no short or glitched period.
- Silence and disable:
  - Divider=100 or 0 with en=1: stays IDLE, sample=0, no period_start.
  - Divider drops to 0 mid-period: RUN continues to the boundary, then IDLE.
  - en=0 mid-period: sample=0 the next cycle.
- rst asserted asynchronously mid-period (between clk edges): sample, active and period_start go to 0 immediately. After release with en=1 and divider=256, the first period_start comes 2 clocks after the first edge.
